// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI read-channel constants, FSM state type and burst address helpers
// for the simulation-side instruction-fetch responder.
package ysyx_23060203_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} rd_state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Wrap span minus one is (len+1)*4-1 == {len, 2'b11} for any len.
  function automatic logic [ADDR_W-1:0] next_beat_addr(input logic [ADDR_W-1:0] addr,
                                                        input logic [LEN_W-1:0]  len,
                                                        input logic              is_wrap);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] incr;
    mask = ADDR_W'({len, 2'b11});
    incr = addr + ADDR_W'(4);
    return is_wrap ? ((addr & ~mask) | (incr & mask)) : incr;
  endfunction

endpackage

// File: rtl/ysyx_23060203_axi_rd_responder_if.sv
// AXI4 read address / read data channel bundle between fetch master and responder.
interface ysyx_23060203_axi_rd_responder_if #(
  parameter int unsigned ID_W = 4
);
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060203_word_rom.sv
// Synchronous-read word memory; contents arrive through the preload hook only,
// there is no bus-visible write path.
module ysyx_23060203_word_rom #(
  parameter int unsigned DEPTH_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_i,
  input  logic [DEPTH_W-1:0] index_i,
  output logic [31:0]        data_o,
  input  logic               load_en_i,
  input  logic [DEPTH_W-1:0] load_index_i,
  input  logic [31:0]        load_data_i
);
  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] data_q;

  always_ff @(posedge clock) begin
    if (load_en_i) mem_q[load_index_i] <= load_data_i;
  end

  // Output holds between reads so a stalled beat keeps its data.
  always_ff @(posedge clock) begin
    if (reset)     data_q <= '0;
    else if (en_i) data_q <= mem_q[index_i];
  end

  assign data_o = data_q;
endmodule

// File: rtl/ysyx_23060203_axi_rd_responder.sv
// AXI4 read-only responder serving ICache refills and single reads from a word ROM,
// with INCR/WRAP bursts, fixed first-beat latency and one outstanding transaction.
module ysyx_23060203_axi_rd_responder
  import ysyx_23060203_axi_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH_W = 16,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ID_W    = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  ysyx_23060203_axi_rd_responder_if.slave axi,
  input  logic                            preload_en_i,
  input  logic [DEPTH_W-1:0]              preload_idx_i,
  input  logic [31:0]                     preload_data_i
);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              wrap_q, wrap_d;
  logic              slverr_q, slverr_d;
  logic [1:0]        resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_off;
  logic              rd_in_range;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] ar_addr_aligned;
  logic              ar_err;
  logic              is_last;
  logic [31:0]       rom_data;

  assign ar_addr_aligned = axi.araddr & ~ADDR_W'(3);
  assign ar_err = (axi.arsize != SIZE_WORD)
               || !((axi.arburst == BURST_INCR) || (axi.arburst == BURST_WRAP))
               || ((axi.arburst == BURST_WRAP) && !wrap_len_ok(axi.arlen));
  assign nxt_addr = next_beat_addr(addr_q, len_q, wrap_q);
  assign is_last  = (beat_q == len_q);

  // Address of whichever beat would be issued this cycle, per state.
  always_comb begin
    rd_addr = addr_q;
    unique case (state_q)
      IDLE:    rd_addr = ar_addr_aligned;
      WAIT:    rd_addr = addr_q;
      BEAT:    rd_addr = nxt_addr;
      default: rd_addr = addr_q;
    endcase
  end

  assign rd_off      = rd_addr - BASE;
  assign rd_in_range = (rd_addr >= BASE) && ((rd_off >> (DEPTH_W + 2)) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wrap_q   <= 1'b0;
      slverr_q <= 1'b0;
      resp_q   <= RESP_OKAY;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      wrap_q   <= wrap_d;
      slverr_q <= slverr_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wrap_d   = wrap_q;
    slverr_d = slverr_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;
    rd_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (axi.arvalid) begin
          addr_d   = ar_addr_aligned;
          id_d     = axi.arid;
          len_d    = axi.arlen;
          beat_d   = '0;
          wrap_d   = (axi.arburst == BURST_WRAP);
          slverr_d = ar_err;
          cnt_d    = CNT_W'(LATENCY - 1);
          // With a one-cycle latency beat 0 must be read on the handshake itself.
          if (LATENCY <= 1) begin
            rd_en   = 1'b1;
            state_d = BEAT;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rd_en   = 1'b1;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (axi.rready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            addr_d = nxt_addr;
            beat_d = beat_q + 8'd1;
            rd_en  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Response is decided per beat at issue time and travels alongside the ROM read.
    if (rd_en) begin
      if (slverr_d)         resp_d = RESP_SLVERR;
      else if (rd_in_range) resp_d = RESP_OKAY;
      else                  resp_d = RESP_DECERR;
    end
  end

  ysyx_23060203_word_rom #(
    .DEPTH_W (DEPTH_W)
  ) u_rom (
    .clock        (clock),
    .reset        (reset),
    .en_i         (rd_en),
    .index_i      (rd_off[DEPTH_W+1:2]),
    .data_o       (rom_data),
    .load_en_i    (preload_en_i),
    .load_index_i (preload_idx_i),
    .load_data_i  (preload_data_i)
  );

  assign axi.arready = (state_q == IDLE);
  assign axi.rvalid  = (state_q == BEAT);
  assign axi.rlast   = (state_q == BEAT) && is_last;
  assign axi.rresp   = resp_q;
  assign axi.rid     = id_q;
  assign axi.rdata   = (resp_q == RESP_OKAY) ? rom_data : '0;
endmodule

// File: tb/tb_ysyx_23060203_axi_rd_responder.sv
// Directed scoreboard bench for the AXI read responder: latency, INCR/WRAP order,
// backpressure, error responses and reset mid-burst.
module tb_ysyx_23060203_axi_rd_responder;
  import ysyx_23060203_axi_pkg::*;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned DEPTH   = 1 << DEPTH_W;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pl_en = 1'b0;
  logic [DEPTH_W-1:0] pl_idx = '0;
  logic [31:0]        pl_data = '0;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ysyx_23060203_axi_rd_responder_if #(.ID_W(4)) bus ();

  ysyx_23060203_axi_rd_responder #(
    .BASE    (BASE),
    .DEPTH_W (DEPTH_W),
    .LATENCY (2),
    .ID_W    (4)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .axi            (bus.slave),
    .preload_en_i   (pl_en),
    .preload_idx_i  (pl_idx),
    .preload_data_i (pl_data)
  );

  function automatic logic [31:0] mem_val(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0007);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Builds the expected beat list from the AR fields using modulo wrap arithmetic.
  task automatic push_exp(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [2:0] size);
    beat_t       e;
    bit          err;
    logic [31:0] a, span, lower;
    err  = (size != 3'b010) || !(burst == 2'b01 || burst == 2'b10) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a    = addr & 32'hFFFF_FFFC;
    span = (32'(len) + 32'd1) * 32'd4;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.last = (b == int'(len));
      if (err) begin
        e.resp = 2'b10; e.data = '0;
      end else if (a >= BASE && a < BASE + 32'(4 * DEPTH)) begin
        e.resp = 2'b00; e.data = mem_val(int'((a - BASE) >> 2));
      end else begin
        e.resp = 2'b11; e.data = '0;
      end
      exp_q.push_back(e);
      if (burst == 2'b10) begin
        lower = a - (a % span);
        a     = lower + ((a - lower + 32'd4) % span);
      end else begin
        a = a + 32'd4;
      end
    end
  endtask

  // Drives one AR handshake; returns at the negedge after it, where the FSM waits.
  task automatic do_ar(input string tag, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [3:0] id, input logic [2:0] size);
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
    bus.arburst = burst; bus.arid = id; bus.arsize = size;
    chk({tag, ".arready_idle"}, 32'(bus.arready), 32'd1);
    push_exp(addr, len, burst, id, size);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk({tag, ".arready_busy"}, 32'(bus.arready), 32'd0);
    chk({tag, ".rvalid_early"}, 32'(bus.rvalid), 32'd0);
  endtask

  // Drains n beats; bp selects the 1,0,0 rready pattern. Stalled beats are
  // compared against the same queue head each cycle, which checks they hold.
  task automatic collect(input string tag, input int n, input bit bp);
    int  got = 0;
    int  cyc = 0;
    bit  first = 1'b1;
    beat_t e;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      bus.rready = bp ? (cyc % 3 == 0) : 1'b1;
      cyc++;
      if (bus.rvalid) begin
        if (first) begin
          chk({tag, ".latency"}, 32'(cyc), 32'd1);
          first = 1'b0;
        end
        chk({tag, ".arready_hold"}, 32'(bus.arready), 32'd0);
        if (exp_q.size() == 0) begin
          chk({tag, ".extra_beat"}, 32'(bus.rvalid), 32'd0);
        end else begin
          e = exp_q[0];
          chk($sformatf("%s.b%0d.rdata", tag, got), bus.rdata, e.data);
          chk($sformatf("%s.b%0d.rresp", tag, got), 32'(bus.rresp), 32'(e.resp));
          chk($sformatf("%s.b%0d.rlast", tag, got), 32'(bus.rlast), 32'(e.last));
          chk($sformatf("%s.b%0d.rid", tag, got), 32'(bus.rid), 32'(e.id));
          if (bus.rready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
    end
    if (got < n) chk({tag, ".timeout_beats"}, 32'(got), 32'(n));
    @(negedge clk);
    bus.rready = 1'b0;
    chk({tag, ".idle_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, ".idle_arready"}, 32'(bus.arready), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = 3'b010; bus.arburst = 2'b01; bus.rready = 1'b0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk); pl_en = 1'b1; pl_idx = DEPTH_W'(i); pl_data = mem_val(i);
    end
    for (int i = DEPTH - 8; i < DEPTH; i++) begin
      @(negedge clk); pl_en = 1'b1; pl_idx = DEPTH_W'(i); pl_data = mem_val(i);
    end
    @(negedge clk); pl_en = 1'b0;

    chk("rst.arready", 32'(bus.arready), 32'd1);
    chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst.rlast", 32'(bus.rlast), 32'd0);
    chk("rst.rresp", 32'(bus.rresp), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.rid", 32'(bus.rid), 32'd0);
    rst = 1'b0;

    do_ar("single", 32'h8000_0010, 8'd0, BURST_INCR, 4'h5, SIZE_WORD);
    collect("single", 1, 1'b0);

    do_ar("incr4", 32'h8000_0000, 8'd3, BURST_INCR, 4'h3, SIZE_WORD);
    collect("incr4", 4, 1'b0);

    do_ar("wrap4", 32'h8000_0018, 8'd3, BURST_WRAP, 4'h9, SIZE_WORD);
    collect("wrap4", 4, 1'b0);

    do_ar("bp_incr8", 32'h8000_0020, 8'd7, BURST_INCR, 4'hA, SIZE_WORD);
    collect("bp_incr8", 8, 1'b1);

    do_ar("bp_wrap8", 32'h8000_0034, 8'd7, BURST_WRAP, 4'h2, SIZE_WORD);
    collect("bp_wrap8", 8, 1'b1);

    do_ar("decerr", BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, BURST_INCR, 4'h1, SIZE_WORD);
    collect("decerr", 2, 1'b0);

    do_ar("size_err", 32'h8000_0000, 8'd2, BURST_INCR, 4'h4, 3'b001);
    collect("size_err", 3, 1'b0);

    do_ar("fixed_err", 32'h8000_0008, 8'd1, BURST_FIXED, 4'h7, SIZE_WORD);
    collect("fixed_err", 2, 1'b0);

    do_ar("wraplen_err", 32'h8000_0008, 8'd2, BURST_WRAP, 4'hB, SIZE_WORD);
    collect("wraplen_err", 3, 1'b1);

    do_ar("unaligned", 32'h8000_0013, 8'd1, BURST_INCR, 4'hC, SIZE_WORD);
    collect("unaligned", 2, 1'b0);

    do_ar("midrst", 32'h8000_0040, 8'd7, BURST_INCR, 4'h6, SIZE_WORD);
    @(negedge clk);
    bus.rready = 1'b1;
    chk("midrst.b0.rvalid", 32'(bus.rvalid), 32'd1);
    chk("midrst.b0.rdata", bus.rdata, exp_q[0].data);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.rready = 1'b0;
    chk("midrst.b1.rvalid", 32'(bus.rvalid), 32'd1);
    chk("midrst.b1.rdata", bus.rdata, exp_q[0].data);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("midrst.arready", 32'(bus.arready), 32'd1);
    chk("midrst.rlast", 32'(bus.rlast), 32'd0);
    chk("midrst.rdata", bus.rdata, 32'd0);
    chk("midrst.rid", 32'(bus.rid), 32'd0);
    exp_q.delete();

    do_ar("post_rst", 32'h8000_0030, 8'd3, BURST_WRAP, 4'hD, SIZE_WORD);
    collect("post_rst", 4, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
